hot_to_bin_stream: RTL and testbench
====================================

// Module: hot_to_bin_stream
// PURPOSE
// - Registered, handshaked one-hot/multi-hot to binary index encoder.
// - Generalises the combinational one-hot decoder: accepts any hot vector and either
//   - emits one index with an error flag (ONEHOT mode), or
//   - serialises every set bit as one index per beat (SERIAL mode).
// - Sits between arbiter/grant or mask producers and index-consuming stream logic.
// PARAMETERS
// - WIDTH      16                                   input vector width, >= 1
// - MODE       hot_enc_pkg::SERIAL                  hot_enc_mode_e: ONEHOT | SERIAL
// - MSB_FIRST  1'b0                                 0: lowest set bit first; 1: highest first
// - IDX_WIDTH  WIDTH==1 ? 1 : $clog2(WIDTH)         derived, do not override
// PORTS
// - clk_i    in   1          clock, all state on rising edge
// - rst_i    in   1          asynchronous reset, active-high
// - vec_i    in   WIDTH      hot vector, qualified by valid_i
// - valid_i  in   1          input valid
// - ready_o  out  1          input ready
// - idx_o    out  IDX_WIDTH  binary index of the current set bit
// - empty_o  out  1          beat carries an all-zero vector; idx_o = 0
// - err_o    out  1          ONEHOT mode: vector had >1 bit set; tied 0 in SERIAL
// - last_o   out  1          final beat of the current vector
// - valid_o  out  1          output valid
// - ready_i  in   1          output ready
// BEHAVIOUR
// - Reset (async, rst_i=1):
//   - state IDLE; valid_o, idx_o, empty_o, err_o, last_o = 0; residual mask = 0.
//   - ready_o = 1 once state is IDLE (also while rst_i is held).
// - Handshakes:
//   - Transfer occurs when valid & ready are high on a clock edge.
//   - valid_o must not drop, and idx_o/empty_o/err_o/last_o must not change, until accepted.
//   - ready_o does not depend on valid_i.
// - FSM IDLE -> BUSY on input accept.
//   - BUSY -> IDLE on the last_o beat accept, unless a new vector is accepted the same cycle.
//   - ready_o = (state==IDLE) | (valid_o & ready_i & last_o). Back-to-back vectors incur no bubble.
// - Latency: first beat valid_o in the cycle after acceptance (1 cycle). SERIAL mode delivers
//   one beat per cycle while ready_i=1.
// - SERIAL mode:
//   - Accepted vec_i is captured into a residual mask.
//   - idx_o = index of the lowest set bit (highest if MSB_FIRST).
//   - Each output accept clears that bit.
//   - last_o = 1 when exactly one bit remains.
//   - N set bits -> exactly N beats.
// - ONEHOT mode: exactly one beat, last_o=1.
//   - idx_o = priority-selected bit per MSB_FIRST.
//   - err_o = 1 if popcount > 1.
// - Zero vector (both modes): one beat with empty_o=1, idx_o=0, last_o=1, err_o=0.
// - WIDTH==1: idx_o is always 0; vec_i=1 gives one beat, vec_i=0 gives an empty beat.
// - Reset mid-vector: residual beats are discarded; no beat after reset until a new accept.
// CONFIGURATION
// - Macro HOT_TO_BIN_STREAM_COUNT_EN.
// - Defined:
//   - Adds output port cnt_o [$clog2(WIDTH+1)-1:0] = popcount of the vector in flight.
//   - cnt_o is registered at acceptance and held constant for every beat of that vector.
//   - cnt_o resets to 0; it is 0 for empty beats.
// - Not defined: port and popcount logic are absent; all other behaviour is identical.
// STRUCTURE
// - Package hot_enc_pkg:
//   - hot_enc_mode_e {ONEHOT, SERIAL}
//   - state enum hot_enc_state_e {IDLE, BUSY}
// - Sub-module hot_prio_enc: combinational priority encoder.
//   - Params WIDTH, MSB_FIRST; ports vec_i -> idx_o, empty_o, multi_o.
//   - Instantiated once on the input side (ONEHOT mode) or on the residual mask (SERIAL mode).
// TESTING
// - SERIAL, WIDTH=16, vec_i=16'h8421, ready_i=1
//   -> beats idx 0,5,10,15 on 4 consecutive cycles; last_o only on idx 15.
// - SERIAL, MSB_FIRST=1, vec_i=16'h0011, ready_i held 0 for 3 cycles
//   -> idx_o=4 stable while stalled, then idx 4, then idx 0 with last_o.
// - ONEHOT, vec_i=16'h0090 -> single beat idx_o=7, err_o=1, last_o=1.
//   Then vec_i=16'h0040 -> idx_o=6, err_o=0.
// - Zero vector -> one beat empty_o=1, idx_o=0, last_o=1.
//   Back-to-back next vector accepted in the same cycle (ready_o=1 on the last beat).
// - Assert rst_i during the 2nd beat of 16'hFFFF
//   -> valid_o=0 immediately, ready_o=1; no residual beats after release.
// - COUNT_EN defined, vec_i=16'h00FF -> cnt_o=8 on all 8 beats.

Source files
------------

// File: rtl/hot_enc_pkg.sv
// Shared types and helpers for the hot-vector to binary-index stream encoder.
package hot_enc_pkg;

   // Encoder personality: one index per vector, or one index per set bit
   typedef enum logic {
      ONEHOT = 1'b0,
      SERIAL = 1'b1
   } hot_enc_mode_e;

   // Stream controller state: IDLE means no beat is being presented
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } hot_enc_state_e;

   // Index width for a vector of the given width (a 1-bit vector still needs a 1-bit index)
   function automatic int idx_width(input int width);
      return (width == 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/hot_prio_enc.sv
// Combinational priority encoder: reports the index of the lowest (or highest)
// set bit, whether the vector is all zero, and whether more than one bit is set.
module hot_prio_enc
   import hot_enc_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b0,
   parameter int IDX_WIDTH = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0]     vec_i,
   output logic [IDX_WIDTH-1:0] idx_o,
   output logic                 empty_o,
   output logic                 multi_o
);

   // Scan so that the bit with the winning priority is the last one written
   always_comb begin
      idx_o = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) idx_o = IDX_WIDTH'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_WIDTH'(i);
         end
      end
   end

   assign empty_o = ~|vec_i;
   // Clearing the lowest set bit leaves something behind only if two or more were set
   assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule

// File: rtl/hot_to_bin_stream.sv
// Registered, handshaked one-hot / multi-hot to binary index encoder.
// ONEHOT mode emits one beat per vector (with a multi-hot error flag);
// SERIAL mode emits one beat per set bit from a residual mask.
// Optional feature: define HOT_TO_BIN_STREAM_COUNT_EN to add cnt_o, the
// popcount of the vector currently being streamed.
module hot_to_bin_stream
   import hot_enc_pkg::*;
#(
   parameter int            WIDTH     = 16,
   parameter hot_enc_mode_e MODE      = SERIAL,
   parameter bit            MSB_FIRST = 1'b0,
   parameter int            IDX_WIDTH = idx_width(WIDTH)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [WIDTH-1:0]             vec_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [IDX_WIDTH-1:0]         idx_o,
   output logic                         empty_o,
   output logic                         err_o,
   output logic                         last_o,
   output logic                         valid_o,
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
   output logic [$clog2(WIDTH+1)-1:0]   cnt_o,
`endif
   input  logic                         ready_i
);

   hot_enc_state_e       state_q, state_d;
   logic [WIDTH-1:0]     mask_q, mask_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic                 empty_q, empty_d;
   logic                 err_q, err_d;

   logic [WIDTH-1:0]     enc_vec;
   logic [IDX_WIDTH-1:0] enc_idx;
   logic                 enc_empty;
   logic                 enc_multi;

   logic                 busy;
   logic                 beat_last;
   logic                 out_fire;
   logic                 in_fire;

   // SERIAL walks the residual mask; ONEHOT only ever looks at the incoming vector
   assign enc_vec = (MODE == SERIAL) ? mask_q : vec_i;

   hot_prio_enc #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_prio_enc (
      .vec_i   (enc_vec),
      .idx_o   (enc_idx),
      .empty_o (enc_empty),
      .multi_o (enc_multi)
   );

   // Handshake status; ready_o looks only at the output side so it never depends on valid_i
   always_comb begin
      busy      = (state_q == BUSY);
      beat_last = (MODE == SERIAL) ? ~enc_multi : 1'b1;
      out_fire  = busy & ready_i;
      ready_o   = ~busy | (out_fire & beat_last);
      in_fire   = valid_i & ready_o;
   end

   // Next state: retire the current beat, then let a new vector overwrite everything
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      empty_d = empty_q;
      err_d   = err_q;
      if (out_fire) begin
         mask_d = mask_q & ~(WIDTH'(1) << enc_idx);
         if (beat_last) state_d = IDLE;
      end
      if (in_fire) begin
         state_d = BUSY;
         mask_d  = (MODE == SERIAL) ? vec_i : '0;
         idx_d   = (MODE == SERIAL) ? '0 : enc_idx;
         empty_d = (MODE == SERIAL) ? ~|vec_i : enc_empty;
         err_d   = (MODE == ONEHOT) & enc_multi;
      end
   end

   // State and beat registers; reset drops any beats still pending
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         idx_q   <= '0;
         empty_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced to zero whenever no beat is presented
   assign valid_o = busy;
   assign idx_o   = busy ? ((MODE == SERIAL) ? enc_idx : idx_q) : '0;
   assign empty_o = busy & empty_q;
   assign err_o   = busy & err_q;
   assign last_o  = busy & beat_last;

`ifdef HOT_TO_BIN_STREAM_COUNT_EN
   localparam int CNT_WIDTH = $clog2(WIDTH + 1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Popcount captured at acceptance and held for every beat of that vector
   always_comb begin
      cnt_d = cnt_q;
      if (in_fire) begin
         cnt_d = '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + CNT_WIDTH'(vec_i[i]);
         end
      end
   end

   // Popcount register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = busy ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_hot_to_bin_stream.sv
// Testbench for hot_to_bin_stream: four instances (SERIAL LSB-first, SERIAL
// MSB-first, ONEHOT MSB-first, SERIAL WIDTH=1) each driven in turn and compared
// against a bit-list reference model. Checks cnt_o when
// HOT_TO_BIN_STREAM_COUNT_EN is defined.
module tb_hot_to_bin_stream;
   import hot_enc_pkg::*;

   localparam int NDUT = 4;
   localparam int CW   = 5;

   typedef struct {
      int idx;
      bit empty;
      bit err;
      bit last;
      int cnt;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] vec       [NDUT];
   logic        valid_in  [NDUT];
   logic        ready_in  [NDUT];
   logic        ready_out [NDUT];
   logic        valid_out [NDUT];
   logic        empty_out [NDUT];
   logic        err_out   [NDUT];
   logic        last_out  [NDUT];
   logic [3:0]  idx_out   [NDUT];
   logic        idx_w1;
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
   logic [CW-1:0] cnt_out [NDUT];
   logic          cnt_w1;
`endif

   int cfg_w      [NDUT] = '{16, 16, 16, 1};
   bit cfg_onehot [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
   bit cfg_msb    [NDUT] = '{1'b0, 1'b1, 1'b1, 1'b0};

   beat_t       exp_q[$];
   logic [15:0] stim_q[$];
   int          check_count = 0;
   int          pass_count  = 0;

   always #5 clk = ~clk;

   hot_to_bin_stream #(.WIDTH(16), .MODE(SERIAL), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk), .rst_i(rst), .vec_i(vec[0]), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
      .idx_o(idx_out[0]), .empty_o(empty_out[0]), .err_o(err_out[0]), .last_o(last_out[0]),
      .valid_o(valid_out[0]),
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
      .cnt_o(cnt_out[0]),
`endif
      .ready_i(ready_in[0]));

   hot_to_bin_stream #(.WIDTH(16), .MODE(SERIAL), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk), .rst_i(rst), .vec_i(vec[1]), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
      .idx_o(idx_out[1]), .empty_o(empty_out[1]), .err_o(err_out[1]), .last_o(last_out[1]),
      .valid_o(valid_out[1]),
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
      .cnt_o(cnt_out[1]),
`endif
      .ready_i(ready_in[1]));

   hot_to_bin_stream #(.WIDTH(16), .MODE(ONEHOT), .MSB_FIRST(1'b1)) u_onehot (
      .clk_i(clk), .rst_i(rst), .vec_i(vec[2]), .valid_i(valid_in[2]), .ready_o(ready_out[2]),
      .idx_o(idx_out[2]), .empty_o(empty_out[2]), .err_o(err_out[2]), .last_o(last_out[2]),
      .valid_o(valid_out[2]),
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
      .cnt_o(cnt_out[2]),
`endif
      .ready_i(ready_in[2]));

   hot_to_bin_stream #(.WIDTH(1), .MODE(SERIAL), .MSB_FIRST(1'b0)) u_w1 (
      .clk_i(clk), .rst_i(rst), .vec_i(vec[3][0]), .valid_i(valid_in[3]), .ready_o(ready_out[3]),
      .idx_o(idx_w1), .empty_o(empty_out[3]), .err_o(err_out[3]), .last_o(last_out[3]),
      .valid_o(valid_out[3]),
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
      .cnt_o(cnt_w1),
`endif
      .ready_i(ready_in[3]));

   assign idx_out[3] = {3'b000, idx_w1};
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
   assign cnt_out[3] = {4'b0000, cnt_w1};
`endif

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Reference model: list the set bits in delivery order and turn them into beats
   function automatic void modelVector(input int d, input logic [15:0] v);
      int    pos[$];
      int    n;
      beat_t b;
      if (cfg_msb[d]) begin
         for (int i = cfg_w[d] - 1; i >= 0; i--) if (v[i]) pos.push_back(i);
      end else begin
         for (int i = 0; i < cfg_w[d]; i++) if (v[i]) pos.push_back(i);
      end
      n = pos.size();
      if (n == 0) begin
         b.idx = 0; b.empty = 1'b1; b.err = 1'b0; b.last = 1'b1; b.cnt = 0;
         exp_q.push_back(b);
      end else if (cfg_onehot[d]) begin
         b.idx = pos[0]; b.empty = 1'b0; b.err = (n > 1); b.last = 1'b1; b.cnt = n;
         exp_q.push_back(b);
      end else begin
         for (int k = 0; k < n; k++) begin
            b.idx = pos[k]; b.empty = 1'b0; b.err = 1'b0; b.last = (k == n - 1); b.cnt = n;
            exp_q.push_back(b);
         end
      end
   endfunction

   function automatic bit pickReady(input int mode, input int cyc, input int stall);
      if (cyc < stall) return 1'b0;
      if (mode == 0)   return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // One cycle: check what the DUT shows, drive new inputs, then advance the model
   task automatic applyStimulus(input int d, input bit drv_valid, input logic [15:0] v,
                                input bit rdy, output bit accepted);
      beat_t b;
      bit    exp_ready;
      @(negedge clk);
      checkOutput($sformatf("d%0d valid_o", d), int'(valid_out[d]), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         b = exp_q[0];
         checkOutput($sformatf("d%0d idx_o", d),   int'(idx_out[d]),   b.idx);
         checkOutput($sformatf("d%0d empty_o", d), int'(empty_out[d]), int'(b.empty));
         checkOutput($sformatf("d%0d err_o", d),   int'(err_out[d]),   int'(b.err));
         checkOutput($sformatf("d%0d last_o", d),  int'(last_out[d]),  int'(b.last));
`ifdef HOT_TO_BIN_STREAM_COUNT_EN
         checkOutput($sformatf("d%0d cnt_o", d),   int'(cnt_out[d]),   b.cnt);
`endif
      end
      valid_in[d] = drv_valid;
      vec[d]      = v;
      ready_in[d] = rdy;
      #1;
      exp_ready = (exp_q.size() == 0) || (rdy && exp_q.size() == 1);
      checkOutput($sformatf("d%0d ready_o", d), int'(ready_out[d]), int'(exp_ready));
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      accepted = drv_valid && exp_ready;
      if (accepted) modelVector(d, v);
   endtask

   // Push every queued vector through instance d, then drain and confirm it goes idle
   task automatic runVectors(input int d, input int ready_mode, input int stall);
      int cyc = 0;
      int waited;
      bit acc;
      while (stim_q.size() > 0) begin
         if (ready_mode == 1 && $urandom_range(0, 3) == 0) begin
            applyStimulus(d, 1'b0, 16'h0, pickReady(ready_mode, cyc, stall), acc);
            cyc++;
         end
         waited = 0;
         acc    = 1'b0;
         while (!acc && waited < 64) begin
            applyStimulus(d, 1'b1, stim_q[0], pickReady(ready_mode, cyc, stall), acc);
            cyc++;
            waited++;
         end
         if (!acc) checkOutput($sformatf("d%0d accept_timeout", d), 0, 1);
         void'(stim_q.pop_front());
      end
      waited = 0;
      while (exp_q.size() > 0 && waited < 200) begin
         applyStimulus(d, 1'b0, 16'h0, pickReady(ready_mode, cyc, stall), acc);
         cyc++;
         waited++;
      end
      checkOutput($sformatf("d%0d drain", d), exp_q.size(), 0);
      exp_q.delete();
      applyStimulus(d, 1'b0, 16'h0, 1'b1, acc);
   endtask

   function automatic logic [15:0] randVector();
      int sel = $urandom_range(0, 3);
      if (sel == 0) return 16'h0000;
      if (sel == 1) return 16'h0001 << $urandom_range(0, 15);
      return 16'($urandom);
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int n;
      rst = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         vec[d] = '0; valid_in[d] = 1'b0; ready_in[d] = 1'b0;
      end
      #1 rst = 1'b1;

      // Reset state, observed while reset is still held
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("d%0d rst valid_o", d), int'(valid_out[d]), 0);
         checkOutput($sformatf("d%0d rst ready_o", d), int'(ready_out[d]), 1);
         checkOutput($sformatf("d%0d rst idx_o", d),   int'(idx_out[d]),   0);
         checkOutput($sformatf("d%0d rst last_o", d),  int'(last_out[d]),  0);
         checkOutput($sformatf("d%0d rst empty_o", d), int'(empty_out[d]), 0);
         checkOutput($sformatf("d%0d rst err_o", d),   int'(err_out[d]),   0);
      end
      rst = 1'b0;

      // Directed: 8421 serial, then empty vector, then back-to-back follow-ups
      stim_q = '{16'h8421, 16'h0000, 16'h0003, 16'h00FF};
      runVectors(0, 0, 0);

      // Directed: MSB-first with a three-cycle stall on the first beat
      stim_q = '{16'h0011};
      runVectors(1, 0, 4);

      // Directed: ONEHOT multi-hot error, clean one-hot, zero vector
      stim_q = '{16'h0090, 16'h0040, 16'h0000, 16'h8000};
      runVectors(2, 0, 0);

      // Directed: WIDTH=1 set and empty beats
      stim_q = '{16'h0001, 16'h0000, 16'h0001, 16'h0001};
      runVectors(3, 0, 0);

      // Random vectors with random output backpressure on every instance
      for (int d = 0; d < NDUT; d++) begin
         for (int k = 0; k < 25; k++) stim_q.push_back(randVector());
         runVectors(d, 1, 0);
      end

      // Reset during the second beat of an all-ones vector
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 8) begin
         applyStimulus(0, 1'b1, 16'hFFFF, 1'b1, acc);
         n++;
      end
      checkOutput("rst_mid accept", int'(acc), 1);
      applyStimulus(0, 1'b0, 16'h0, 1'b1, acc);
      @(negedge clk);
      checkOutput("rst_mid pre valid_o", int'(valid_out[0]), 1);
      checkOutput("rst_mid pre idx_o",   int'(idx_out[0]),   1);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid valid_o", int'(valid_out[0]), 0);
      checkOutput("rst_mid ready_o", int'(ready_out[0]), 1);
      checkOutput("rst_mid idx_o",   int'(idx_out[0]),   0);
      checkOutput("rst_mid last_o",  int'(last_out[0]),  0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) applyStimulus(0, 1'b0, 16'h0, 1'b1, acc);
      stim_q = '{16'h0005};
      runVectors(0, 0, 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
